ad4008_readout: RTL and testbench

AD4008_READOUT -- requirements
Module: ad4008_readout

---
 rtl/ad4008_pkg.sv | 18 +
 rtl/ad4008_sck_gen.sv | 50 +++++
 rtl/ad4008_readout.sv | 128 ++++++++++++
 tb/tb_ad4008_readout.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad4008_pkg.sv
// AD4008 readout shared types: FSM state enum and default parameters.
// No ports; imported by ad4008_readout and ad4008_sck_gen.
package ad4008_pkg;

  localparam int DEF_ADC_WIDTH       = 16;
  localparam int DEF_CNV_HIGH_CYCLES = 2;
  localparam int DEF_CONV_TIMEOUT    = 100;
  localparam int DEF_SCK_DIV         = 4;

  typedef enum logic [2:0] {
    IDLE,
    CNV_HIGH,
    WAIT_BUSY,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/ad4008_sck_gen.sv
// SCK generator: half-period counter, rise/fall strobes, pulse counter.
// Ports: clk, rst_n, en in; sck, rise, fall, first, last out.
module ad4008_sck_gen
  import ad4008_pkg::*;
#(
  parameter int ADC_WIDTH = DEF_ADC_WIDTH,
  parameter int SCK_DIV   = DEF_SCK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall,
  output logic first,
  output logic last
);

  localparam int HW = $clog2(SCK_DIV);
  localparam int PW = $clog2(ADC_WIDTH + 2);

  logic [HW-1:0] hcnt;
  logic [PW-1:0] pcnt;
  logic          tick;

  // tick marks the clk cycle whose closing edge toggles sck
  assign tick  = en && (hcnt == HW'(SCK_DIV - 1));
  assign rise  = tick && !sck;
  assign fall  = tick && sck;
  // pcnt counts completed rising edges
  assign first = (pcnt == '0);
  assign last  = (pcnt == PW'(ADC_WIDTH + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      pcnt <= '0;
      sck  <= 1'b0;
    end else if (!en) begin
      hcnt <= '0;
      pcnt <= '0;
      sck  <= 1'b0;
    end else begin
      hcnt <= tick ? '0 : hcnt + 1'b1;
      if (tick) sck <= !sck;
      if (rise) pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/ad4008_readout.sv
// AD4008 single-conversion readout with busy indicator on sdo.
// Ports: clk, rst_n, start, sdo in; cnv, sck, data, data_valid, busy, timeout_err out.
module ad4008_readout
  import ad4008_pkg::*;
#(
  parameter int ADC_WIDTH       = DEF_ADC_WIDTH,
  parameter int CNV_HIGH_CYCLES = DEF_CNV_HIGH_CYCLES,
  parameter int CONV_TIMEOUT    = DEF_CONV_TIMEOUT,
  parameter int SCK_DIV         = DEF_SCK_DIV
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sdo,
  output logic                 cnv,
  output logic                 sck,
  output logic [ADC_WIDTH-1:0] data,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int TO_W = $clog2(CONV_TIMEOUT + 1);
  localparam int CH_W = $clog2(CNV_HIGH_CYCLES + 1);

  logic [1:0]           rst_pipe;
  logic                 rst_sync;
  logic [1:0]           sdo_pipe;
  logic                 sdo_s;
  state_t               state;
  state_t               state_next;
  logic [CH_W-1:0]      ccnt;
  logic [TO_W-1:0]      tcnt;
  logic [ADC_WIDTH-1:0] shreg;
  logic                 to_hit;
  logic                 rise;
  logic                 fall;
  logic                 first;
  logic                 last;

  // assert immediately, release after two clk edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync = rst_pipe[1];

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) sdo_pipe <= '0;
    else           sdo_pipe <= {sdo_pipe[0], sdo};
  end
  assign sdo_s = sdo_pipe[1];

  ad4008_sck_gen #(
    .ADC_WIDTH (ADC_WIDTH),
    .SCK_DIV   (SCK_DIV)
  ) u_sck (
    .clk   (clk),
    .rst_n (rst_sync),
    .en    (state == SHIFT),
    .sck   (sck),
    .rise  (rise),
    .fall  (fall),
    .first (first),
    .last  (last)
  );

  always_comb begin
    state_next = state;
    to_hit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = CNV_HIGH;
      end
      CNV_HIGH: begin
        if (ccnt == CH_W'(CNV_HIGH_CYCLES - 1))
          state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // end-of-conversion wins over a same-cycle timeout
        if (!sdo_s) begin
          state_next = SHIFT;
        end else if (tcnt == TO_W'(CONV_TIMEOUT)) begin
          state_next = IDLE;
          to_hit     = 1'b1;
        end
      end
      SHIFT: begin
        if (fall && last) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state       <= IDLE;
      cnv         <= 1'b0;
      busy        <= 1'b0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
      ccnt        <= '0;
      tcnt        <= '0;
      shreg       <= '0;
      data        <= '0;
    end else begin
      state       <= state_next;
      cnv         <= (state_next == CNV_HIGH);
      busy        <= (state_next != IDLE);
      data_valid  <= (state_next == DONE);
      timeout_err <= to_hit;
      ccnt <= (state == CNV_HIGH) ? ccnt + 1'b1 : '0;
      tcnt <= (state == WAIT_BUSY && state_next == WAIT_BUSY)
              ? tcnt + 1'b1 : '0;
      // first rising edge precedes valid MSB on sdo
      if (rise && !first)
        shreg <= {shreg[ADC_WIDTH-2:0], sdo_s};
      if (state_next == DONE)
        data <= shreg;
    end
  end

endmodule

// File: tb/tb_ad4008_readout.sv
// Self-checking bench for ad4008_readout with a behavioural ADC model.
// u0 uses default parameters, u1 runs at the minimum SCK divider.
module tb_ad4008_readout;

  typedef struct {
    logic [15:0] word;
    logic        stuck;
    logic [15:0] exp_data;
    int          exp_valid;
    int          exp_to;
    int          exp_rise;
    int          exp_cnv;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  start_w = '0;
  logic [1:0]  stuck_in = '0;
  logic [15:0] word_in [2];
  wire  [1:0]  cnv_w, sck_w, busy_w, dv_w, to_w, sdo_w;
  wire  [15:0] data0, data1;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  ad4008_readout u0 (
    .clk (clk), .rst_n (rst_n), .start (start_w[0]), .sdo (sdo_w[0]),
    .cnv (cnv_w[0]), .sck (sck_w[0]), .data (data0),
    .data_valid (dv_w[0]), .busy (busy_w[0]), .timeout_err (to_w[0])
  );

  ad4008_readout #(.SCK_DIV(3)) u1 (
    .clk (clk), .rst_n (rst_n), .start (start_w[1]), .sdo (sdo_w[1]),
    .cnv (cnv_w[1]), .sck (sck_w[1]), .data (data1),
    .data_valid (dv_w[1]), .busy (busy_w[1]), .timeout_err (to_w[1])
  );

  for (genvar g = 0; g < 2; g++) begin : adc
    logic        sdo_r = 1'b1;
    logic        cnv_p = 1'b0;
    logic        sck_p = 1'b0;
    logic        mon_sck = 1'b0;
    logic [15:0] cur = '0;
    int          bitn = -1;
    int          cd = 0;
    int          n_valid = 0;
    int          n_to = 0;
    int          n_cnv = 0;
    int          n_rise = 0;
    int          n_ovl = 0;

    assign sdo_w[g] = sdo_r;

    always begin
      @(posedge clk);
      #1;
      if (cnv_w[g] && !cnv_p) begin
        cur   = word_in[g];
        sdo_r = 1'b1;
        bitn  = -1;
        cd    = 29;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0 && !stuck_in[g]) begin
          sdo_r = 1'b0;
          bitn  = 15;
        end
      end
      if (!sck_w[g] && sck_p) begin
        if (bitn >= 0) begin
          sdo_r = cur[bitn];
          bitn--;
        end else begin
          sdo_r = 1'b1;
        end
      end
      cnv_p = cnv_w[g];
      sck_p = sck_w[g];
    end

    always @(negedge clk) begin
      if (dv_w[g]) n_valid++;
      if (to_w[g]) n_to++;
      if (cnv_w[g]) n_cnv++;
      if (sck_w[g] && !mon_sck) n_rise++;
      if (cnv_w[g] && sck_w[g]) n_ovl++;
      mon_sck = sck_w[g];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy_low(input int idx);
    int cyc;
    cyc = 0;
    while (busy_w[idx] && cyc < 2000) begin
      tick();
      cyc++;
    end
    chk("busy_drop_in_time", cyc < 2000, 1);
    @(negedge clk);
    tick();
  endtask

  task automatic run0(input logic [15:0] w, input logic st,
                      output int dv, output int to,
                      output int ri, output int cv);
    int v0, t0, r0, c0;
    v0 = adc[0].n_valid;
    t0 = adc[0].n_to;
    r0 = adc[0].n_rise;
    c0 = adc[0].n_cnv;
    word_in[0]  = w;
    stuck_in[0] = st;
    start_w[0]  = 1'b1;
    tick();
    start_w[0]  = 1'b0;
    wait_busy_low(0);
    dv = adc[0].n_valid - v0;
    to = adc[0].n_to - t0;
    ri = adc[0].n_rise - r0;
    cv = adc[0].n_cnv - c0;
    stuck_in[0] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t        tab [5];
    logic [15:0] w3 [2];
    int          dv, to, ri, cv, n, k, v0, c0, r0;

    tab[0] = '{16'hA5C3, 1'b0, 16'hA5C3, 1, 0, 17, 2};
    tab[1] = '{16'h0000, 1'b0, 16'h0000, 1, 0, 17, 2};
    tab[2] = '{16'hFFFF, 1'b0, 16'hFFFF, 1, 0, 17, 2};
    tab[3] = '{16'h5AA5, 1'b0, 16'h5AA5, 1, 0, 17, 2};
    tab[4] = '{16'h1357, 1'b1, 16'h5AA5, 0, 1, 0, 2};
    w3[0] = 16'h8001;
    w3[1] = 16'h7FFE;
    word_in[0] = '0;
    word_in[1] = '0;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cnv", cnv_w[0], 0);
    chk("rst_sck", sck_w[0], 0);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_dv", dv_w[0], 0);
    chk("rst_to", to_w[0], 0);
    chk("rst_data", data0, 0);
    rst_n = 1'b1;
    repeat (5) tick();

    // start latency, cnv width, DONE -> IDLE
    word_in[0] = 16'h0F0F;
    chk("idle_busy", busy_w[0], 0);
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    chk("cnv_c1", cnv_w[0], 1);
    chk("busy_c1", busy_w[0], 1);
    tick();
    chk("cnv_c2", cnv_w[0], 1);
    tick();
    chk("cnv_c3", cnv_w[0], 0);
    chk("busy_c3", busy_w[0], 1);
    n = 0;
    while (!dv_w[0] && n < 1000) begin tick(); n++; end
    chk("dv_seen", dv_w[0], 1);
    chk("done_data", data0, 16'h0F0F);
    tick();
    chk("idle1_busy", busy_w[0], 0);
    chk("idle1_dv", dv_w[0], 0);
    chk("hold_data", data0, 16'h0F0F);
    repeat (3) tick();
    chk("hold_data2", data0, 16'h0F0F);

    for (int i = 0; i < 5; i++) begin
      run0(tab[i].word, tab[i].stuck, dv, to, ri, cv);
      chk($sformatf("vec%0d_data", i), data0, tab[i].exp_data);
      chk($sformatf("vec%0d_valid", i), dv, tab[i].exp_valid);
      chk($sformatf("vec%0d_to", i), to, tab[i].exp_to);
      chk($sformatf("vec%0d_rise", i), ri, tab[i].exp_rise);
      chk($sformatf("vec%0d_cnv", i), cv, tab[i].exp_cnv);
      chk($sformatf("vec%0d_busy", i), busy_w[0], 0);
    end

    // timeout latency from cnv falling
    v0 = adc[0].n_valid;
    word_in[0]  = 16'h7777;
    stuck_in[0] = 1'b1;
    start_w[0]  = 1'b1;
    tick();
    start_w[0]  = 1'b0;
    n = 0;
    while (cnv_w[0] && n < 50) begin tick(); n++; end
    k = 0;
    while (!to_w[0] && k < 300) begin tick(); k++; end
    chk("to_latency", k, 101);
    chk("to_busy", busy_w[0], 0);
    chk("to_data", data0, 16'h5AA5);
    tick();
    chk("to_one_cycle", to_w[0], 0);
    chk("to_no_dv", adc[0].n_valid - v0, 0);
    stuck_in[0] = 1'b0;
    repeat (5) tick();

    // start held high: back-to-back conversions
    v0 = adc[0].n_valid;
    word_in[0] = 16'h0000;
    start_w[0] = 1'b1;
    n = 0;
    while (!dv_w[0] && n < 1000) begin tick(); n++; end
    chk("b2b_first", data0, 16'h0000);
    word_in[0] = 16'hFFFF;
    k = 0;
    while (!cnv_w[0] && k < 20) begin tick(); k++; end
    chk("b2b_gap", k, 2);
    start_w[0] = 1'b0;
    tick();
    n = 0;
    while (!dv_w[0] && n < 1000) begin tick(); n++; end
    chk("b2b_second", data0, 16'hFFFF);
    repeat (20) tick();
    chk("b2b_count", adc[0].n_valid - v0, 2);
    chk("b2b_idle", busy_w[0], 0);

    // reset during the 8th SCK pulse
    v0 = adc[0].n_valid;
    r0 = adc[0].n_rise;
    word_in[0] = 16'hBEEF;
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    n = 0;
    while (!((adc[0].n_rise - r0) >= 8 && sck_w[0]) && n < 2000) begin
      tick();
      n++;
    end
    chk("abort_pulse", adc[0].n_rise - r0, 8);
    rst_n = 1'b0;
    #1;
    chk("abort_cnv", cnv_w[0], 0);
    chk("abort_sck", sck_w[0], 0);
    chk("abort_busy", busy_w[0], 0);
    chk("abort_dv", dv_w[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("abort_no_dv", adc[0].n_valid - v0, 0);
    chk("abort_data", data0, 0);
    run0(16'h1234, 1'b0, dv, to, ri, cv);
    chk("after_abort_data", data0, 16'h1234);
    chk("after_abort_dv", dv, 1);

    // start during SHIFT is ignored
    v0 = adc[0].n_valid;
    c0 = adc[0].n_cnv;
    r0 = adc[0].n_rise;
    word_in[0] = 16'h3C5A;
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    n = 0;
    while ((adc[0].n_rise - r0) < 3 && n < 2000) begin tick(); n++; end
    start_w[0] = 1'b1;
    tick();
    start_w[0] = 1'b0;
    wait_busy_low(0);
    repeat (10) tick();
    chk("ign_dv", adc[0].n_valid - v0, 1);
    chk("ign_cnv", adc[0].n_cnv - c0, 2);
    chk("ign_data", data0, 16'h3C5A);
    chk("ign_busy", busy_w[0], 0);

    // minimum divider
    for (int i = 0; i < 2; i++) begin
      v0 = adc[1].n_valid;
      r0 = adc[1].n_rise;
      word_in[1] = w3[i];
      start_w[1] = 1'b1;
      tick();
      start_w[1] = 1'b0;
      wait_busy_low(1);
      chk($sformatf("div3_data%0d", i), data1, w3[i]);
      chk($sformatf("div3_dv%0d", i), adc[1].n_valid - v0, 1);
      chk($sformatf("div3_rise%0d", i), adc[1].n_rise - r0, 17);
    end

    chk("cnv_sck_overlap", adc[0].n_ovl + adc[1].n_ovl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
